// File: rtl/bram_stream_reader.sv
// Burst reader: fetches a contiguous BRAM range (1-cycle read latency) and
// streams it out over valid/ready, with a 2-entry buffer absorbing in-flight reads.
module bram_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [LEN_WIDTH-1:0]  i_num,
   output logic                  o_idle,
   output logic                  o_done,
   output logic                  o_bram_en,
   output logic [ADDR_WIDTH-1:0] o_bram_addr,
   input  logic [DATA_WIDTH-1:0] i_bram_rdata,
   output logic                  o_m_valid,
   input  logic                  i_m_ready,
   output logic [DATA_WIDTH-1:0] o_m_data,
   output logic                  o_m_last
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [LEN_WIDTH-1:0]  num_q, num_d;
   logic [LEN_WIDTH-1:0]  issued_q, issued_d;
   logic [LEN_WIDTH-1:0]  popped_q, popped_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic [DATA_WIDTH-1:0] fifo_d [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            cnt_q, cnt_d;

   logic                  pop;
   logic                  issue;
   logic [2:0]            occupancy;
   logic [2:0]            limit;

   assign pop = o_m_valid && i_m_ready;

   // A read may go out only if the words already buffered or in flight,
   // less the one leaving this cycle, leave a free FIFO slot for it.
   assign occupancy = 3'(cnt_q) + 3'(inflight_q);
   assign limit     = 3'd2 + 3'(pop);
   assign issue     = (state_q == S_RUN) && (issued_q < num_q) && (occupancy < limit);

   assign o_bram_en   = issue;
   assign o_bram_addr = issue ? base_q + ADDR_WIDTH'(issued_q) : '0;
   assign o_m_valid   = (cnt_q != 2'd0);
   assign o_m_data    = fifo_q[rd_ptr_q];
   assign o_m_last    = o_m_valid && (popped_q == num_q - LEN_WIDTH'(1));
   assign o_idle      = (state_q == S_IDLE);
   assign o_done      = (state_q == S_DONE);

   // NOTE: every signal gets a default before any branch so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      num_d      = num_q;
      issued_d   = issued_q;
      popped_d   = popped_q;
      inflight_d = issue;
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q + 2'(inflight_q) - 2'(pop);

      if (inflight_q) begin
         fifo_d[wr_ptr_q] = i_bram_rdata;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
         popped_d = popped_q + LEN_WIDTH'(1);
      end
      if (issue) begin
         issued_d = issued_q + LEN_WIDTH'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               base_d   = i_base_addr;
               num_d    = i_num;
               issued_d = '0;
               popped_d = '0;
               state_d  = (i_num == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (pop && o_m_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments only; the two buffer words are
   // reset as well so o_m_data reads zero out of reset.
   always_ff @(posedge clk) begin
      if (areset) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         inflight_q <= 1'b0;
         fifo_q     <= '{default: '0};
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         num_q      <= num_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         inflight_q <= inflight_d;
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: BRAM model plus a transfer-level
// reference (expected words, addresses, cycle timing) with random backpressure.
module tb_bram_stream_reader;

   localparam int DW = 8;
   localparam int AW = 10;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          areset;
   logic          i_start;
   logic [AW-1:0] i_base_addr;
   logic [LW-1:0] i_num;
   logic          o_idle;
   logic          o_done;
   logic          o_bram_en;
   logic [AW-1:0] o_bram_addr;
   logic [DW-1:0] i_bram_rdata;
   logic          o_m_valid;
   logic          i_m_ready;
   logic [DW-1:0] o_m_data;
   logic          o_m_last;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW-1:0] bram [1 << AW];

   bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk          (clk),
      .areset       (areset),
      .i_start      (i_start),
      .i_base_addr  (i_base_addr),
      .i_num        (i_num),
      .o_idle       (o_idle),
      .o_done       (o_done),
      .o_bram_en    (o_bram_en),
      .o_bram_addr  (o_bram_addr),
      .i_bram_rdata (i_bram_rdata),
      .o_m_valid    (o_m_valid),
      .i_m_ready    (i_m_ready),
      .o_m_data     (o_m_data),
      .o_m_last     (o_m_last)
   );

   always #5 clk = ~clk;

   // Single-port BRAM, 1-cycle read latency.
   always @(posedge clk) begin
      if (o_bram_en) i_bram_rdata <= bram[o_bram_addr];
   end

   // Runs one transfer. Cycle 0 is the start cycle. timing=1 checks the exact
   // cycle schedule (ready must be held high). reset_cyc>0 asserts areset in
   // that cycle and checks reset values in the next one.
   task automatic run_xfer(input logic [AW-1:0] base, input int num, input int ready_pct,
                           input int restart_cyc, input int reset_cyc, input bit timing);
      int            n_issued  = 0;
      int            n_popped  = 0;
      bit            finished  = 1'b0;
      bit            prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      logic          prev_last = 1'b0;
      int            exp_done  = (num == 0) ? 1 : 3 + num;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      bit            hs;

      @(posedge clk); #1;
      i_start     = 1'b1;
      i_base_addr = base;
      i_num       = LW'(num);
      i_m_ready   = 1'b1;
      @(negedge clk);
      n_checks++;
      if (o_idle !== 1'b1 || o_done !== 1'b0)
         $display("FAIL start_idle: idle=%b done=%b, required idle=1 done=0", o_idle, o_done);
      else n_pass++;

      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(posedge clk); #1;
         i_start     = (cyc == restart_cyc);
         i_base_addr = base + AW'(7);
         i_num       = LW'(num + 5);
         areset      = (reset_cyc > 0) && (cyc == reset_cyc);
         i_m_ready   = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk);

         if (reset_cyc > 0 && cyc == reset_cyc + 1) begin
            n_checks++;
            if ({o_idle, o_done, o_bram_en, o_bram_addr, o_m_valid, o_m_data, o_m_last} !==
                {1'b1, 1'b0, 1'b0, {AW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0})
               $display("FAIL mid_reset_outputs: idle=%b done=%b en=%b addr=%h valid=%b data=%h last=%b, required 1 0 0 000 0 00 0",
                        o_idle, o_done, o_bram_en, o_bram_addr, o_m_valid, o_m_data, o_m_last);
            else n_pass++;
            finished = 1'b1;
            break;
         end

         hs = o_m_valid && i_m_ready;

         if (timing) begin
            n_checks++;
            if (o_bram_en !== (cyc >= 1 && cyc <= num))
               $display("FAIL timing_en cyc %0d: en=%b, required %b", cyc, o_bram_en, (cyc >= 1 && cyc <= num));
            else n_pass++;
            n_checks++;
            if (o_m_valid !== (cyc >= 3 && cyc <= 2 + num))
               $display("FAIL timing_valid cyc %0d: valid=%b, required %b", cyc, o_m_valid, (cyc >= 3 && cyc <= 2 + num));
            else n_pass++;
            n_checks++;
            if (o_done !== (cyc == exp_done))
               $display("FAIL timing_done cyc %0d: done=%b, required %b", cyc, o_done, (cyc == exp_done));
            else n_pass++;
         end

         if (o_bram_en) begin
            exp_addr = AW'(int'(base) + n_issued);
            n_checks++;
            if (n_issued >= num || o_bram_addr !== exp_addr)
               $display("FAIL bram_addr read %0d: addr=%h, required %h (of %0d reads)", n_issued, o_bram_addr, exp_addr, num);
            else n_pass++;
            // Words read but not yet delivered, after this cycle's handshake, must be < 2.
            n_checks++;
            if (n_issued - n_popped - int'(hs) >= 2)
               $display("FAIL occupancy read %0d: outstanding=%0d, required < 2", n_issued, n_issued - n_popped - int'(hs));
            else n_pass++;
            n_issued++;
         end

         if (prev_stall) begin
            n_checks++;
            if (o_m_valid !== 1'b1 || o_m_data !== prev_data || o_m_last !== prev_last)
               $display("FAIL stall_hold: valid=%b data=%h last=%b, required 1 %h %b",
                        o_m_valid, o_m_data, o_m_last, prev_data, prev_last);
            else n_pass++;
         end

         if (o_m_valid) begin
            n_checks++;
            if (o_m_last !== (n_popped == num - 1))
               $display("FAIL last beat %0d: last=%b, required %b", n_popped, o_m_last, (n_popped == num - 1));
            else n_pass++;
         end

         if (hs) begin
            exp_data = bram[AW'(int'(base) + n_popped)];
            n_checks++;
            if (n_popped >= num || o_m_data !== exp_data)
               $display("FAIL beat_data beat %0d: data=%h, required %h (of %0d beats)", n_popped, o_m_data, exp_data, num);
            else n_pass++;
            n_popped++;
         end

         prev_stall = o_m_valid && !i_m_ready;
         prev_data  = o_m_data;
         prev_last  = o_m_last;

         if (o_done) begin
            n_checks++;
            if (n_popped !== num || n_issued !== num)
               $display("FAIL beat_count: beats=%0d reads=%0d, required %0d", n_popped, n_issued, num);
            else n_pass++;
            finished = 1'b1;
            break;
         end
      end

      areset    = 1'b0;
      i_start   = 1'b0;
      n_checks++;
      if (!finished) $display("FAIL xfer_timeout: finished=0, required 1");
      else n_pass++;
   endtask

   task automatic test_reset();
      areset    = 1'b1;
      i_start   = 1'b0;
      i_base_addr = '0;
      i_num     = '0;
      i_m_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({o_idle, o_done, o_bram_en, o_bram_addr, o_m_valid, o_m_data, o_m_last} !==
          {1'b1, 1'b0, 1'b0, {AW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0})
         $display("FAIL reset_values: idle=%b done=%b en=%b addr=%h valid=%b data=%h last=%b, required 1 0 0 000 0 00 0",
                  o_idle, o_done, o_bram_en, o_bram_addr, o_m_valid, o_m_data, o_m_last);
      else n_pass++;
      @(posedge clk); #1;
      areset = 1'b0;
   endtask

   task automatic test_basic();
      for (int i = 0; i < (1 << AW); i++) bram[i] = DW'(i);
      run_xfer(10'h010, 4, 100, -1, -1, 1'b1);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < (1 << AW); i++) bram[i] = DW'($urandom);
      run_xfer(10'h3FE, 4, 100, -1, -1, 1'b1);
   endtask

   task automatic test_backpressure();
      run_xfer(AW'($urandom), 16, 50, -1, -1, 1'b0);
      run_xfer(10'h3F8, 16, 30, -1, -1, 1'b0);
   endtask

   task automatic test_zero_len();
      run_xfer(10'h123, 0, 100, -1, -1, 1'b1);
   endtask

   task automatic test_restart_ignored();
      run_xfer(10'h040, 8, 100, 4, -1, 1'b1);
   endtask

   task automatic test_mid_reset();
      run_xfer(10'h080, 8, 100, -1, 5, 1'b0);
      run_xfer(10'h020, 2, 100, -1, -1, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 6; t++)
         run_xfer(AW'($urandom), $urandom_range(0, 12), $urandom_range(20, 100), -1, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_restart_ignored();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "watchdog");
   end

endmodule
